instr_memory_wrapper: RTL and testbench

Instruction memory for the MIPS datapath: 1024 × 32-bit dual-port distributed RAM with one synchronous write port (loader/debug side) and one asynchronous read port (fetch side). Each word has a valid bit cleared by reset, so never-written words read as zero instead of X. The fetch stage drives `dpra` with the word-index PC and uses `dpo` combinationally in the same cycle.

---
 rtl/instr_mem_pkg.sv | 11 +
 rtl/dist_ram_1024x32.sv | 32 +++
 rtl/instr_memory_wrapper.sv | 85 ++++++++
 tb/tb_instr_memory_wrapper.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared constants and types for the instruction memory and the fetch stage.
package instr_mem_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] iaddr_t;
    typedef logic [DATA_W-1:0] iword_t;

endpackage

// File: rtl/dist_ram_1024x32.sv
// Raw dual-port distributed RAM: one synchronous write port, two asynchronous
// read ports, no reset on the data array so it maps onto LUT RAM.
module dist_ram_1024x32 #(
    parameter int ADDR_W = instr_mem_pkg::ADDR_W,
    parameter int DATA_W = instr_mem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Synchronous write port; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Both reads are combinational (distributed RAM behaviour).
    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/instr_memory_wrapper.sv
// Instruction memory: dual-port distributed RAM plus a per-word valid bit so
// never-written words read as zero. Optional write-first forwarding on both
// read ports is enabled by defining INSTR_MEM_BYPASS_EN.
module instr_memory_wrapper #(
    parameter int ADDR_W = instr_mem_pkg::ADDR_W,
    parameter int DATA_W = instr_mem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] a,
    input  logic [DATA_W-1:0] d,
    input  logic [ADDR_W-1:0] dpra,
    output logic [DATA_W-1:0] dpo,
    output logic [DATA_W-1:0] spo
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic              ram_we;
    logic [DATA_W-1:0] dpo_raw;
    logic [DATA_W-1:0] spo_raw;
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_d;
    logic [DEPTH-1:0]  valid_set;

    // Writes are dropped while reset is held, including on the asserting edge.
    assign ram_we = we & rst_n;

    dist_ram_1024x32 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk       (clk),
        .we_i      (ram_we),
        .waddr_i   (a),
        .wdata_i   (d),
        .raddr_a_i (a),
        .raddr_b_i (dpra),
        .rdata_a_o (spo_raw),
        .rdata_b_o (dpo_raw)
    );

    // One-hot decode of the write address into per-word valid set strobes.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid_dec
            assign valid_set[gi] = we && (a == ADDR_W'(gi));
        end
    endgenerate

    assign valid_d = valid_q | valid_set;

    // Valid bits: cleared asynchronously by reset, set by each write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Read gating: zero for unwritten words and while reset is asserted.
    always_comb begin
        dpo = '0;
        spo = '0;
        if (rst_n) begin
            if (valid_q[dpra]) begin
                dpo = dpo_raw;
            end
            if (valid_q[a]) begin
                spo = spo_raw;
            end
`ifdef INSTR_MEM_BYPASS_EN
            // Write-first forwarding: a pending write is visible before its edge.
            if (we && (a == dpra)) begin
                dpo = d;
            end
            if (we) begin
                spo = d;
            end
`endif
        end
    end

endmodule

// File: tb/tb_instr_memory_wrapper.sv
// Directed self-checking bench for instr_memory_wrapper with a scoreboard queue.
module tb_instr_memory_wrapper;
    import instr_mem_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n;
    logic   we;
    iaddr_t a;
    iword_t d;
    iaddr_t dpra;
    iword_t dpo;
    iword_t spo;

    int n_tests = 0;
    int n_fail  = 0;

    iword_t exp_q[$];

    instr_memory_wrapper dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .a     (a),
        .d     (d),
        .dpra  (dpra),
        .dpo   (dpo),
        .spo   (spo)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input iword_t v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input iword_t got);
        iword_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: observed %h, scoreboard empty", tag, got);
            return;
        end
        e = exp_q.pop_front();
        assert (got === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, e);
        end
        $display("[TB] %s observed=%h expected=%h", tag, got, e);
    endtask

    task automatic write_word(input iaddr_t addr, input iword_t data);
        we = 1'b1;
        a  = addr;
        d  = data;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic read_dp(input string tag, input iaddr_t addr, input iword_t exp);
        dpra = addr;
        push_exp(exp);
        #1;
        check(tag, dpo);
    endtask

    task automatic read_sp(input string tag, input iaddr_t addr, input iword_t exp);
        a = addr;
        push_exp(exp);
        #1;
        check(tag, spo);
    endtask

    initial begin
        rst_n = 1'b0;
        we    = 1'b0;
        a     = '0;
        d     = '0;
        dpra  = '0;

        // Reset state
        push_exp(32'h0000_0000);
        #1;
        check("rst_dpo", dpo);
        push_exp(32'h0000_0000);
        check("rst_spo", spo);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reads after reset
        read_dp("post_rst_0",    10'd0,    32'h0000_0000);
        read_dp("post_rst_5",    10'd5,    32'h0000_0000);
        read_dp("post_rst_1023", 10'd1023, 32'h0000_0000);

        // Single write / read back
        write_word(10'd5, 32'h3AFE_BABE);
        read_dp("wr5_dpo", 10'd5, 32'h3AFE_BABE);
        read_sp("wr5_spo", 10'd5, 32'h3AFE_BABE);

        // Second write
        write_word(10'd15, 32'hFACE_FEED);
        read_dp("wr15_dpo",  10'd15, 32'hFACE_FEED);
        read_dp("keep5_dpo", 10'd5,  32'h3AFE_BABE);
        read_dp("never25",   10'd25, 32'h0000_0000);

        // Same-address write: before and after the edge
        dpra = 10'd7;
        a    = 10'd7;
        d    = 32'h1234_5678;
        we   = 1'b1;
        #1;
`ifdef INSTR_MEM_BYPASS_EN
        push_exp(32'h1234_5678);
        check("same_pre_dpo", dpo);
        push_exp(32'h1234_5678);
        check("same_pre_spo", spo);
`else
        push_exp(32'h0000_0000);
        check("same_pre_dpo", dpo);
        push_exp(32'h0000_0000);
        check("same_pre_spo", spo);
`endif
        @(posedge clk);
        #1;
        we = 1'b0;
        push_exp(32'h1234_5678);
        #1;
        check("same_post_dpo", dpo);
        push_exp(32'h1234_5678);
        check("same_post_spo", spo);

        // we=0 leaves contents unchanged
        a = 10'd7;
        d = 32'h0BAD_0BAD;
        @(posedge clk);
        #1;
        read_dp("we0_keep7", 10'd7, 32'h1234_5678);

        // Reset mid-operation
        dpra = 10'd5;
        a    = 10'd5;
        #1;
        push_exp(32'h3AFE_BABE);
        check("pre_rst_5", dpo);
        rst_n = 1'b0;
        #1;
        push_exp(32'h0000_0000);
        check("in_rst_dpo", dpo);
        push_exp(32'h0000_0000);
        check("in_rst_spo", spo);
        we = 1'b1;
        a  = 10'd9;
        d  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        we    = 1'b0;
        rst_n = 1'b1;
        read_dp("after_rst_5", 10'd5, 32'h0000_0000);
        read_dp("after_rst_9", 10'd9, 32'h0000_0000);
        read_sp("after_rst_9_spo", 10'd9, 32'h0000_0000);

        // Boundary addresses
        write_word(10'd0,    32'hAAAA_AAAA);
        write_word(10'd1023, 32'h5555_5555);
        read_dp("bnd_0",    10'd0,    32'hAAAA_AAAA);
        read_dp("bnd_1023", 10'd1023, 32'h5555_5555);
        read_dp("bnd_1",    10'd1,    32'h0000_0000);
        read_dp("bnd_1022", 10'd1022, 32'h0000_0000);
        read_sp("bnd_0_spo",    10'd0,    32'hAAAA_AAAA);
        read_sp("bnd_1023_spo", 10'd1023, 32'h5555_5555);

        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
